// File: rtl/periph_burst_reader.sv
// periph_burst_reader: drains the granted peripheral RX FIFO in bounded bursts.
// Each word is tagged with its source ID and offered on a valid/ready port.
// read_periph_data pulses at the end of every burst so the arbiter can move on.
module periph_burst_reader #(
   parameter int NUM_PERIPH = 8,
   parameter int ID_W       = 3,
   parameter int DATA_W     = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ID_W-1:0]              grant,
   input  logic [NUM_PERIPH-1:0]        rx_fifo_empty,
   input  logic [NUM_PERIPH*DATA_W-1:0] rx_fifo_dout,
   output logic [NUM_PERIPH-1:0]        rx_fifo_rd_en,
   output logic                         read_periph_data,
   output logic [DATA_W-1:0]            tx_data,
   output logic [ID_W-1:0]              tx_id,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic                         busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [NUM_PERIPH-1:0] ONE_HOT_0 = NUM_PERIPH'(1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      WAIT    = 3'd2,
      SEND    = 3'd3,
      RELEASE = 3'd4,
      SETTLE  = 3'd5
   } state_t;

   state_t                  state_q;
   logic [ID_W-1:0]         sel_q;
   logic [CNT_W-1:0]        count_q;
   logic [CNT_W-1:0]        count_d;
   logic [DATA_W-1:0]       data_q;
   logic [ID_W-1:0]         id_q;
   logic                    valid_q;
   logic [NUM_PERIPH-1:0]   rd_en_q;
   logic                    release_q;

   // Per-FIFO view of the flattened read-data bus
   logic [DATA_W-1:0]       dout_arr [NUM_PERIPH];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PERIPH; gi++) begin : g_dout
         assign dout_arr[gi] = rx_fifo_dout[gi*DATA_W +: DATA_W];
      end
   endgenerate

   logic                    grant_empty;
   logic                    sel_empty;
   logic [DATA_W-1:0]       sel_dout;
   logic                    accept;

   assign grant_empty = rx_fifo_empty[grant];
   assign sel_empty   = rx_fifo_empty[sel_q];
   assign sel_dout    = dout_arr[sel_q];
   assign accept      = valid_q && tx_ready;
   assign count_d     = count_q + 1'b1;

   // Burst FSM; all strobes and the TX port are registered here
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         count_q   <= '0;
         data_q    <= '0;
         id_q      <= '0;
         valid_q   <= 1'b0;
         rd_en_q   <= '0;
         release_q <= 1'b0;
      end else begin
         // Single-cycle strobes default low
         rd_en_q   <= '0;
         release_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Grant is only honoured here; it is latched for the whole burst
               if (!grant_empty) begin
                  sel_q   <= grant;
                  rd_en_q <= ONE_HOT_0 << grant;
                  state_q <= READ;
               end
            end
            READ: begin
               state_q <= WAIT;
            end
            WAIT: begin
               // FIFO data is valid the cycle after the pop strobe
               data_q  <= sel_dout;
               id_q    <= sel_q;
               valid_q <= 1'b1;
               state_q <= SEND;
            end
            SEND: begin
               if (accept) begin
                  valid_q <= 1'b0;
                  count_q <= count_d;
                  // Empty check here guarantees no pop is ever issued to an empty FIFO
                  if ((count_d == BURST_LAST) || sel_empty) begin
                     release_q <= 1'b1;
                     state_q   <= RELEASE;
                  end else begin
                     rd_en_q <= ONE_HOT_0 << sel_q;
                     state_q <= READ;
                  end
               end
            end
            RELEASE: begin
               count_q <= '0;
               state_q <= SETTLE;
            end
            SETTLE: begin
               // Gives the arbiter's registered grant a cycle to update
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rx_fifo_rd_en    = rd_en_q;
   assign read_periph_data = release_q;
   assign tx_data          = data_q;
   assign tx_id            = id_q;
   assign tx_valid         = valid_q;
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_periph_burst_reader.sv
// Directed bench for periph_burst_reader with a behavioural RX FIFO model.
module tb_periph_burst_reader;

   logic         clk;
   logic         rst;
   logic [2:0]   grant;
   logic [7:0]   rx_fifo_empty;
   logic [255:0] rx_fifo_dout;
   logic [7:0]   rx_fifo_rd_en;
   logic         read_periph_data;
   logic [31:0]  tx_data;
   logic [2:0]   tx_id;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;

   int total = 0;
   int bad   = 0;

   periph_burst_reader #(
      .NUM_PERIPH(8),
      .ID_W(3),
      .DATA_W(32),
      .MAX_BURST(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .grant(grant),
      .rx_fifo_empty(rx_fifo_empty),
      .rx_fifo_dout(rx_fifo_dout),
      .rx_fifo_rd_en(rx_fifo_rd_en),
      .read_periph_data(read_periph_data),
      .tx_data(tx_data),
      .tx_id(tx_id),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- RX FIFO model ----------------
   logic [31:0] mem [0:7][0:255];
   logic [7:0]  wr_ptr [0:7] = '{default: 8'd0};
   logic [7:0]  rd_ptr [0:7] = '{default: 8'd0};
   logic [31:0] dout_r [0:7] = '{default: 32'd0};

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (rx_fifo_rd_en[i] && (wr_ptr[i] != rd_ptr[i])) begin
            dout_r[i] <= mem[i][rd_ptr[i]];
            rd_ptr[i] <= rd_ptr[i] + 8'd1;
         end
      end
   end

   always_comb begin
      rx_fifo_empty = '0;
      rx_fifo_dout  = '0;
      for (int i = 0; i < 8; i++) begin
         rx_fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
         rx_fifo_dout[i*32 +: 32] = dout_r[i];
      end
   end

   task automatic push(input int f, input logic [31:0] d);
      mem[f][wr_ptr[f]] = d;
      wr_ptr[f] = wr_ptr[f] + 8'd1;
   endtask

   // ---------------- Monitor ----------------
   int          cyc = 0;
   int          acc_cnt = 0;
   int          rpd_cnt = 0;
   logic [31:0] acc_data [0:127];
   logic [2:0]  acc_id   [0:127];
   int          acc_cyc  [0:127];
   int          rpd_acc  [0:31];
   int          rd_cnt   [0:7] = '{default: 0};
   int          viol_empty = 0;
   int          viol_oh = 0;
   int          viol_drop = 0;
   int          viol_stable = 0;
   logic        prev_valid = 1'b0;
   logic        prev_acc = 1'b0;
   logic        prev_rst = 1'b0;
   logic [31:0] prev_data = '0;
   logic [2:0]  prev_id = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (tx_valid && tx_ready && acc_cnt < 128) begin
         acc_data[acc_cnt] = tx_data;
         acc_id[acc_cnt]   = tx_id;
         acc_cyc[acc_cnt]  = cyc;
         acc_cnt = acc_cnt + 1;
      end
      for (int i = 0; i < 8; i++) begin
         if (rx_fifo_rd_en[i]) rd_cnt[i] = rd_cnt[i] + 1;
         if (rx_fifo_rd_en[i] && rx_fifo_empty[i]) viol_empty = viol_empty + 1;
      end
      if ($countones(rx_fifo_rd_en) > 1) viol_oh = viol_oh + 1;
      if (read_periph_data && rpd_cnt < 32) begin
         rpd_acc[rpd_cnt] = acc_cnt;
         rpd_cnt = rpd_cnt + 1;
      end
      if (prev_valid && !prev_acc && !tx_valid && !prev_rst) viol_drop = viol_drop + 1;
      if (prev_valid && !prev_acc && tx_valid && !prev_rst &&
          ((tx_data != prev_data) || (tx_id != prev_id))) viol_stable = viol_stable + 1;
      prev_valid = tx_valid;
      prev_acc   = tx_valid && tx_ready;
      prev_rst   = rst;
      prev_data  = tx_data;
      prev_id    = tx_id;
   end

   // ---------------- Helpers ----------------
   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic drive_edge;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!tx_valid && n < 20) begin
         step;
         n++;
      end
      total++;
      if (!tx_valid) begin
         bad++;
         $display("FAIL %s tx_valid timeout got=%b want=1", nm, tx_valid);
      end
   endtask

   task automatic wait_done(input int target, input int budget, input string nm);
      int n = 0;
      while (!(acc_cnt >= target && !busy) && n < budget) begin
         step;
         n++;
      end
      total++;
      if (!(acc_cnt >= target && !busy)) begin
         bad++;
         $display("FAIL %s drain timeout got_acc=%0d want_acc=%0d busy=%b", nm, acc_cnt, target, busy);
      end
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      grant = 3'd0;
      tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      step;
      total++;
      if ({rx_fifo_rd_en, tx_valid, busy, read_periph_data} !== 11'd0) begin
         bad++;
         $display("FAIL reset_ctrl got=%h want=0", {rx_fifo_rd_en, tx_valid, busy, read_periph_data});
      end
      total++;
      if ({tx_data, tx_id} !== 35'd0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0", {tx_data, tx_id});
      end
      drive_edge;
      rst = 1'b0;
   endtask

   task automatic test_single;
      int b_acc, b_rpd, b_rd;
      drive_edge;
      b_acc = acc_cnt; b_rpd = rpd_cnt; b_rd = rd_cnt[2];
      push(2, 32'hA5A5_0001);
      grant = 3'd2;
      tx_ready = 1'b1;
      step;
      total++;
      if (rx_fifo_rd_en !== 8'h00) begin bad++; $display("FAIL t1_c0_rd got=%h want=00", rx_fifo_rd_en); end
      step;
      total++;
      if (rx_fifo_rd_en !== 8'h04) begin bad++; $display("FAIL t1_c1_rd got=%h want=04", rx_fifo_rd_en); end
      step;
      total++;
      if ({rx_fifo_rd_en, tx_valid} !== 9'd0) begin bad++; $display("FAIL t1_c2_wait got=%h want=0", {rx_fifo_rd_en, tx_valid}); end
      step;
      total++;
      if ({tx_valid, tx_data, tx_id} !== {1'b1, 32'hA5A5_0001, 3'd2}) begin
         bad++;
         $display("FAIL t1_c3_send got=%b/%h/%0d want=1/a5a50001/2", tx_valid, tx_data, tx_id);
      end
      step;
      total++;
      if ({read_periph_data, busy} !== 2'b11) begin bad++; $display("FAIL t1_release got=%b want=11", {read_periph_data, busy}); end
      step;
      total++;
      if ({read_periph_data, busy} !== 2'b01) begin bad++; $display("FAIL t1_settle got=%b want=01", {read_periph_data, busy}); end
      step;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL t1_idle_busy got=%b want=0", busy); end
      total++;
      if ({acc_cnt - b_acc, rpd_cnt - b_rpd, rd_cnt[2] - b_rd} !== {32'd1, 32'd1, 32'd1}) begin
         bad++;
         $display("FAIL t1_counts got acc=%0d rpd=%0d rd=%0d want=1/1/1", acc_cnt - b_acc, rpd_cnt - b_rpd, rd_cnt[2] - b_rd);
      end
   endtask

   task automatic test_max_burst;
      int b_acc, b_rpd, b_rd;
      drive_edge;
      b_acc = acc_cnt; b_rpd = rpd_cnt; b_rd = rd_cnt[5];
      for (int k = 0; k < 20; k++) push(5, 32'h5500_0000 + k);
      grant = 3'd5;
      tx_ready = 1'b1;
      wait_done(b_acc + 20, 300, "t2");
      for (int k = 0; k < 20; k++) begin
         total++;
         if ({acc_data[b_acc + k], acc_id[b_acc + k]} !== {32'h5500_0000 + k, 3'd5}) begin
            bad++;
            $display("FAIL t2_word%0d got=%h/%0d want=%h/5", k, acc_data[b_acc + k], acc_id[b_acc + k], 32'h5500_0000 + k);
         end
      end
      total++;
      if (rpd_cnt - b_rpd !== 2) begin bad++; $display("FAIL t2_rpd_count got=%0d want=2", rpd_cnt - b_rpd); end
      total++;
      if (rpd_acc[b_rpd] - b_acc !== 16) begin bad++; $display("FAIL t2_rpd_after got=%0d want=16", rpd_acc[b_rpd] - b_acc); end
      total++;
      if (rpd_acc[b_rpd + 1] - b_acc !== 20) begin bad++; $display("FAIL t2_rpd2_after got=%0d want=20", rpd_acc[b_rpd + 1] - b_acc); end
      total++;
      if (acc_cyc[b_acc + 1] - acc_cyc[b_acc] !== 3) begin
         bad++;
         $display("FAIL t2_throughput got=%0d want=3", acc_cyc[b_acc + 1] - acc_cyc[b_acc]);
      end
      total++;
      if (acc_cyc[b_acc + 16] - acc_cyc[b_acc + 15] !== 6) begin
         bad++;
         $display("FAIL t2_rearb_gap got=%0d want=6", acc_cyc[b_acc + 16] - acc_cyc[b_acc + 15]);
      end
      total++;
      if (rd_cnt[5] - b_rd !== 20) begin bad++; $display("FAIL t2_pops got=%0d want=20", rd_cnt[5] - b_rd); end
   endtask

   task automatic test_backpressure;
      int b_acc, b_rpd, b_rd;
      drive_edge;
      b_acc = acc_cnt; b_rpd = rpd_cnt;
      push(1, 32'h1111_0001);
      push(1, 32'h1111_0002);
      grant = 3'd1;
      tx_ready = 1'b0;
      wait_valid("t3");
      b_rd = rd_cnt[1];
      for (int k = 0; k < 10; k++) begin
         step;
         total++;
         if ({tx_valid, tx_data, tx_id} !== {1'b1, 32'h1111_0001, 3'd1}) begin
            bad++;
            $display("FAIL t3_hold%0d got=%b/%h/%0d want=1/11110001/1", k, tx_valid, tx_data, tx_id);
         end
      end
      total++;
      if (rd_cnt[1] - b_rd !== 0) begin bad++; $display("FAIL t3_no_pop got=%0d want=0", rd_cnt[1] - b_rd); end
      drive_edge;
      tx_ready = 1'b1;
      wait_done(b_acc + 2, 60, "t3");
      total++;
      if ({acc_data[b_acc], acc_data[b_acc + 1]} !== {32'h1111_0001, 32'h1111_0002}) begin
         bad++;
         $display("FAIL t3_words got=%h %h want=11110001 11110002", acc_data[b_acc], acc_data[b_acc + 1]);
      end
      total++;
      if (rpd_cnt - b_rpd !== 1) begin bad++; $display("FAIL t3_rpd got=%0d want=1", rpd_cnt - b_rpd); end
   endtask

   task automatic test_grant_change;
      int b_acc, b_rpd, b_rd3, b_rd6, n;
      drive_edge;
      b_acc = acc_cnt; b_rpd = rpd_cnt; b_rd3 = rd_cnt[3]; b_rd6 = rd_cnt[6];
      for (int k = 0; k < 4; k++) push(3, 32'h3300_0000 + k);
      for (int k = 0; k < 3; k++) push(6, 32'h6600_0000 + k);
      grant = 3'd3;
      tx_ready = 1'b1;
      n = 0;
      while (rd_cnt[3] == b_rd3 && n < 20) begin step; n++; end
      drive_edge;
      grant = 3'd6;
      n = 0;
      while (rpd_cnt == b_rpd && n < 60) begin step; n++; end
      total++;
      if (rpd_cnt - b_rpd !== 1) begin bad++; $display("FAIL t4_release got=%0d want=1", rpd_cnt - b_rpd); end
      total++;
      if ({rd_cnt[6] - b_rd6, rd_cnt[3] - b_rd3} !== {32'd0, 32'd4}) begin
         bad++;
         $display("FAIL t4_pops got rd6=%0d rd3=%0d want=0/4", rd_cnt[6] - b_rd6, rd_cnt[3] - b_rd3);
      end
      total++;
      if (acc_cnt - b_acc !== 4) begin bad++; $display("FAIL t4_burst_len got=%0d want=4", acc_cnt - b_acc); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if ({acc_data[b_acc + k], acc_id[b_acc + k]} !== {32'h3300_0000 + k, 3'd3}) begin
            bad++;
            $display("FAIL t4_word%0d got=%h/%0d want=%h/3", k, acc_data[b_acc + k], acc_id[b_acc + k], 32'h3300_0000 + k);
         end
      end
      wait_done(b_acc + 7, 80, "t4");
      total++;
      if ({acc_id[b_acc + 4], acc_data[b_acc + 6]} !== {3'd6, 32'h6600_0002}) begin
         bad++;
         $display("FAIL t4_next_grant got=%0d/%h want=6/66000002", acc_id[b_acc + 4], acc_data[b_acc + 6]);
      end
   endtask

   task automatic test_reset_in_send;
      int b_acc, b_rpd;
      drive_edge;
      push(4, 32'h4400_0001);
      push(4, 32'h4400_0002);
      grant = 3'd4;
      tx_ready = 1'b0;
      wait_valid("t5");
      b_rpd = rpd_cnt;
      drive_edge;
      rst = 1'b1;
      grant = 3'd0;
      drive_edge;
      rst = 1'b0;
      step;
      total++;
      if ({tx_valid, rx_fifo_rd_en, busy, read_periph_data} !== 11'd0) begin
         bad++;
         $display("FAIL t5_after_rst got=%h want=0", {tx_valid, rx_fifo_rd_en, busy, read_periph_data});
      end
      repeat (5) step;
      total++;
      if ({rpd_cnt - b_rpd, 31'd0, busy} !== 64'd0) begin
         bad++;
         $display("FAIL t5_no_pulse got rpd=%0d busy=%b want=0/0", rpd_cnt - b_rpd, busy);
      end
      drive_edge;
      b_acc = acc_cnt;
      grant = 3'd4;
      tx_ready = 1'b1;
      wait_done(b_acc + 1, 40, "t5");
      total++;
      if (acc_data[b_acc] !== 32'h4400_0002) begin
         bad++;
         $display("FAIL t5_leftover got=%h want=44000002", acc_data[b_acc]);
      end
   endtask

   task automatic test_all_empty;
      total++;
      if (rx_fifo_empty !== 8'hFF) begin bad++; $display("FAIL t6_empty got=%h want=ff", rx_fifo_empty); end
      for (int k = 0; k < 50; k++) begin
         drive_edge;
         grant = 3'(k);
         tx_ready = k[0];
         step;
         total++;
         if ({busy, rx_fifo_rd_en, read_periph_data} !== 10'd0) begin
            bad++;
            $display("FAIL t6_cycle%0d got=%h want=0", k, {busy, rx_fifo_rd_en, read_periph_data});
         end
      end
   endtask

   task automatic test_invariants;
      total++;
      if (viol_empty !== 0) begin bad++; $display("FAIL inv_pop_empty got=%0d want=0", viol_empty); end
      total++;
      if (viol_oh !== 0) begin bad++; $display("FAIL inv_onehot got=%0d want=0", viol_oh); end
      total++;
      if (viol_drop !== 0) begin bad++; $display("FAIL inv_valid_drop got=%0d want=0", viol_drop); end
      total++;
      if (viol_stable !== 0) begin bad++; $display("FAIL inv_stable got=%0d want=0", viol_stable); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_max_burst;
      test_backpressure;
      test_grant_change;
      test_reset_in_send;
      test_all_empty;
      test_invariants;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
